digit_pattern_gen: RTL and testbench

Synthesises a binary raster image of a decimal digit, 0-9, drawn as seven-segment strokes on an IMG_W x IMG_H grid. It emits the image as a ready/valid pixel stream in raster order. It is the generator side of the digit-recognition path: it produces known-good frames that feed the scan/crossing-count logic and the digit classifier, for self-test and bring-up.

---
 rtl/digit_pattern_gen.sv | 125 ++++++++++++
 tb/tb_digit_pattern_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_pattern_gen.sv
// Streams a seven-segment raster image of a decimal digit as raster-order pixels
// over a ready/valid handshake. Used to produce known-good frames for bring-up.
module digit_pattern_gen #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 48,
  parameter int STROKE = 4
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] digit,
  input  logic       out_ready,
  output logic       pixel_valid,
  output logic       pixel,
  output logic [7:0] hcount,
  output logic [7:0] vcount,
  output logic       line_end,
  output logic       frame_end,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int MID = (IMG_H - STROKE) / 2;

  localparam logic [7:0] H_LAST = 8'(IMG_W - 1);
  localparam logic [7:0] V_LAST = 8'(IMG_H - 1);

  // Stroke boundaries widened by one bit so IMG_W/IMG_H of 256 still compare correctly
  localparam logic [8:0] Y_A_END = 9'(STROKE);
  localparam logic [8:0] Y_D_BEG = 9'(IMG_H - STROKE);
  localparam logic [8:0] Y_G_BEG = 9'(MID);
  localparam logic [8:0] Y_G_END = 9'(MID + STROKE);
  localparam logic [8:0] X_L_END = 9'(STROKE);
  localparam logic [8:0] X_R_BEG = 9'(IMG_W - STROKE);

  logic [1:0] state;
  logic [3:0] digit_q;

  // Enabled segments, bit order {a,b,c,d,e,f,g}; out-of-range digits draw nothing
  function automatic logic [6:0] seg_mask(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic seg_hit(input logic [7:0] x, input logic [7:0] y,
                                   input logic [6:0] mask);
    logic [8:0] xe;
    logic [8:0] ye;
    logic [6:0] hit;
    xe     = {1'b0, x};
    ye     = {1'b0, y};
    hit[6] = (ye < Y_A_END);
    hit[5] = (xe >= X_R_BEG) && (ye < Y_G_END);
    hit[4] = (xe >= X_R_BEG) && (ye >= Y_G_BEG);
    hit[3] = (ye >= Y_D_BEG);
    hit[2] = (xe < X_L_END) && (ye >= Y_G_BEG);
    hit[1] = (xe < X_L_END) && (ye < Y_G_END);
    hit[0] = (ye >= Y_G_BEG) && (ye < Y_G_END);
    return |(hit & mask);
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      hcount  <= '0;
      vcount  <= '0;
      digit_q <= 4'hf;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            digit_q <= digit;
            hcount  <= '0;
            vcount  <= '0;
            err     <= (digit > 4'd9);
          end
        end
        S_RUN: begin
          if (out_ready) begin
            if (hcount == H_LAST) begin
              hcount <= '0;
              if (vcount == V_LAST) begin
                vcount <= '0;
                state  <= S_DONE;
              end else begin
                vcount <= vcount + 8'd1;
              end
            end else begin
              hcount <= hcount + 8'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // All outputs decode from registered state only
  assign pixel_valid = (state == S_RUN);
  assign busy        = (state == S_RUN);
  assign done        = (state == S_DONE);
  assign line_end    = pixel_valid & (hcount == H_LAST);
  assign frame_end   = line_end & (vcount == V_LAST);
  assign pixel       = pixel_valid & seg_hit(hcount, vcount, seg_mask(digit_q));

endmodule

// File: tb/tb_digit_pattern_gen.sv
// Scoreboard bench for digit_pattern_gen: expected pixels are queued at start and
// popped on every accepted transfer.
module tb_digit_pattern_gen;

  localparam int IMG_W  = 32;
  localparam int IMG_H  = 48;
  localparam int STROKE = 4;
  localparam int NPIX   = IMG_W * IMG_H;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] digit;
  logic       out_ready;
  logic       pixel_valid;
  logic       pixel;
  logic [7:0] hcount;
  logic [7:0] vcount;
  logic       line_end;
  logic       frame_end;
  logic       busy;
  logic       done;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;
  int xfer_cnt = 0;

  logic [18:0] sb_q[$];
  bit          img [IMG_H][IMG_W];

  digit_pattern_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .STROKE(STROKE)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .digit       (digit),
    .out_ready   (out_ready),
    .pixel_valid (pixel_valid),
    .pixel       (pixel),
    .hcount      (hcount),
    .vcount      (vcount),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic string segs_of(input int d);
    case (d)
      0: return "abcdef";
      1: return "bc";
      2: return "abdeg";
      3: return "abcdg";
      4: return "bcfg";
      5: return "acdfg";
      6: return "acdefg";
      7: return "abc";
      8: return "abcdefg";
      9: return "abcdfg";
      default: return "";
    endcase
  endfunction

  function automatic bit model_pix(input int d, input int x, input int y);
    int    m;
    string s;
    bit    r;
    m = (IMG_H - STROKE) / 2;
    s = segs_of(d);
    r = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": r |= (y < STROKE);
        "b": r |= (x >= IMG_W - STROKE) && (y < m + STROKE);
        "c": r |= (x >= IMG_W - STROKE) && (y >= m);
        "d": r |= (y >= IMG_H - STROKE);
        "e": r |= (x < STROKE) && (y >= m);
        "f": r |= (x < STROKE) && (y < m + STROKE);
        "g": r |= (y >= m) && (y < m + STROKE);
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic push_frame(input int d);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        sb_q.push_back({8'(y), 8'(x), model_pix(d, x, y),
                        (x == IMG_W - 1), (x == IMG_W - 1) && (y == IMG_H - 1)});
  endtask

  // Monitor: every accepted pixel is checked against the head of the scoreboard
  always @(negedge clock) begin
    logic [18:0] got;
    logic [18:0] exp;
    if (pixel_valid && out_ready) begin
      got = {vcount, hcount, pixel, line_end, frame_end};
      if (sb_q.size() == 0) begin
        chk("sb_extra", 32'(sb_q.size()), 32'd1);
      end else begin
        exp = sb_q.pop_front();
        chk("sb_pix", 32'(got), 32'(exp));
      end
      if (int'(vcount) < IMG_H && int'(hcount) < IMG_W) img[vcount][hcount] = pixel;
      xfer_cnt++;
    end
  end

  task automatic pt(input string tag, input int x, input int y, input bit e);
    chk(tag, 32'(img[y][x]), 32'(e));
  endtask

  // mode: 0 plain, 1 backpressure at pixel 100, 2 start during RUN, 3 reset at pixel 700
  task automatic run_frame(input logic [3:0] d, input int mode);
    bit seen_done;
    bit fe_prev;
    bit dropped;
    bit aborted;
    int cyc;
    foreach (img[y, x]) img[y][x] = 1'b0;
    xfer_cnt = 0;
    sb_q.delete();
    push_frame(int'(d));
    @(posedge clock); #1;
    start = 1'b1; digit = d; out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("start_vld", {29'd0, pixel_valid, busy, err}, {29'd0, 1'b1, 1'b1, (d > 4'd9)});
    chk("start_pos", {16'd0, hcount, vcount}, 32'd0);
    seen_done = 0; fe_prev = 0; dropped = 0; aborted = 0;
    for (cyc = 0; cyc < 3 * NPIX && !seen_done && !aborted; cyc++) begin
      if (done) begin
        chk("done_outs", {30'd0, busy, pixel_valid}, 32'd0);
        chk("xfers", 32'(xfer_cnt), 32'(NPIX));
        chk("done_after_fe", 32'(fe_prev), 32'd1);
        seen_done = 1;
      end else begin
        fe_prev = pixel_valid & frame_end & out_ready;
        if (mode == 1 && !dropped && xfer_cnt == 100) begin
          dropped = 1;
          out_ready = 1'b0;
          chk("bp_pos", {16'd0, hcount, vcount}, {16'd0, 8'd4, 8'd3});
          repeat (5) begin
            @(posedge clock); #1;
            chk("bp_hold", {14'd0, pixel_valid, hcount, vcount, pixel},
                {14'd0, 1'b1, 8'd4, 8'd3, model_pix(5, 4, 3)});
          end
          out_ready = 1'b1;
        end
        if (mode == 2 && xfer_cnt == 50) begin
          start = 1'b1; digit = 4'd6;
        end else begin
          start = 1'b0;
        end
        if (mode == 3 && xfer_cnt == 700) begin
          rst_n = 1'b0;
          #1;
          chk("rst_async", {9'd0, pixel_valid, pixel, line_end, frame_end, busy, done, err,
                            hcount, vcount}, 32'd0);
          sb_q.delete();
          repeat (3) begin @(posedge clock); #1; chk("rst_nodone", 32'(done), 32'd0); end
          rst_n = 1'b1;
          repeat (3) begin
            @(posedge clock); #1;
            chk("post_rst_idle", {29'd0, done, busy, pixel_valid}, 32'd0);
          end
          aborted = 1;
        end
      end
      if (!seen_done && !aborted) begin @(posedge clock); #1; end
    end
    start = 1'b0;
    if (!aborted) begin
      chk("frame_done", 32'(seen_done), 32'd1);
      chk("sb_left", 32'(sb_q.size()), 32'd0);
      @(posedge clock); #1;
      chk("done_1cyc", {30'd0, done, busy}, 32'd0);
      chk("err_hold", 32'(err), 32'(d > 4'd9));
    end
  endtask

  initial begin
    int ones;
    rst_n = 1'b0; start = 1'b0; digit = 4'd0; out_ready = 1'b0;
    #1;
    chk("reset", {9'd0, pixel_valid, pixel, line_end, frame_end, busy, done, err,
                  hcount, vcount}, 32'd0);
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;

    run_frame(4'd8, 0);
    pt("d8_16_24", 16, 24, 1'b1);
    pt("d8_16_10", 16, 10, 1'b0);
    pt("d8_0_0", 0, 0, 1'b1);

    run_frame(4'd1, 0);
    pt("d1_31_0", 31, 0, 1'b1);
    pt("d1_0_0", 0, 0, 1'b0);
    pt("d1_16_0", 16, 0, 1'b0);
    pt("d1_30_47", 30, 47, 1'b1);
    pt("d1_16_23", 16, 23, 1'b0);

    run_frame(4'd7, 0);
    pt("d7_16_23", 16, 23, 1'b0);

    run_frame(4'd0, 0);
    pt("d0_16_23", 16, 23, 1'b0);
    pt("d0_0_30", 0, 30, 1'b1);

    run_frame(4'd2, 0);
    pt("d2_31_30", 31, 30, 1'b0);
    pt("d2_0_30", 0, 30, 1'b1);

    run_frame(4'd5, 1);

    run_frame(4'd12, 0);
    ones = 0;
    foreach (img[y, x]) ones += int'(img[y][x]);
    chk("d12_blank", 32'(ones), 32'd0);

    run_frame(4'd3, 2);
    pt("d3_0_30", 0, 30, 1'b0);

    run_frame(4'd9, 3);
    run_frame(4'd8, 0);
    pt("post_rst_0_0", 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
